// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the word-granular DMA engine.
package mem_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_dma_range_check.sv
// Combinational parameter check: flags out-of-range or forward-overlapping requests.
module mem_dma_range_check
  import mem_dma_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  mode,
  output logic                  err_c
);

  localparam int unsigned EW = ADDR_WIDTH + 1;

  logic [EW-1:0] depth;
  logic [EW-1:0] src_end;
  logic [EW-1:0] dst_end;

  // End addresses are one bit wider than the address so nothing wraps.
  always_comb begin
    depth   = EW'(MEM_DEPTH);
    src_end = EW'(src) + len;
    dst_end = EW'(dst) + len;
    err_c   = 1'b0;
    if (dst_end > depth) begin
      err_c = 1'b1;
    end
    if (mode == MODE_COPY) begin
      if (src_end > depth) begin
        err_c = 1'b1;
      end
      // A forward copy would overwrite source words before reading them.
      if ((dst > src) && (EW'(dst) < src_end)) begin
        err_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_dma.sv
// DMA initiator on the shared data-memory port: block copy or constant fill.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic                  mem_gnt,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  output logic                  mem_req,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  range_err_c;

  mem_dma_range_check #(
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_range_check (
    .src   (src_addr),
    .dst   (dst_addr),
    .len   (len),
    .mode  (mode),
    .err_c (range_err_c)
  );

  // State and datapath registers; reset also kills any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_COPY;
      fill_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state and port drive; write enable follows the grant within WRITE only.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    fill_d   = fill_q;
    data_d   = data_q;
    err_d    = err_q;
    mem_addr = '0;
    mem_wd   = '0;
    mem_we   = 1'b0;
    mem_req  = 1'b0;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    err      = (state_q == DONE) && err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          cnt_d  = len;
          mode_d = mode;
          fill_d = fill_value;
          err_d  = range_err_c;
          if (range_err_c || (len == '0)) begin
            state_d = DONE;
          end else if (mode == MODE_FILL) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end

      READ: begin
        mem_req  = 1'b1;
        mem_addr = src_q;
        if (mem_gnt) begin
          data_d  = mem_rd;
          state_d = WRITE;
        end
      end

      WRITE: begin
        mem_req  = 1'b1;
        mem_addr = dst_q;
        mem_wd   = (mode_q == MODE_FILL) ? fill_q : data_q;
        mem_we   = mem_gnt;
        if (mem_gnt) begin
          src_d = src_q + ADDR_WIDTH'(1);
          dst_d = dst_q + ADDR_WIDTH'(1);
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
          end else if (mode_q == MODE_COPY) begin
            state_d = READ;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: directed cases plus randomized copies/fills
// against an array-level reference of memory contents and expected cycle timing.
module tb_mem_dma;

  localparam int DEPTH = 4096;
  localparam int MAXC  = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [11:0] src_addr;
  logic [11:0] dst_addr;
  logic [12:0] len;
  logic [31:0] fill_value;
  logic        mem_gnt;
  logic [31:0] mem_rd;
  logic [11:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic        mem_req;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic         gnt_pat [0:MAXC-1];
  int           done_cyc, exp_done;
  logic         err_seen, exp_err;
  logic [127:0] we_mask, exp_mask;
  int           bad_we, busy_bad;
  logic         req_seen;

  mem_dma dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_value (fill_value),
    .mem_gnt    (mem_gnt),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_req    (mem_req),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Data memory model: asynchronous read, synchronous write (bench preload port first).
  assign mem_rd = mem[mem_addr];
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wd;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  function automatic logic gnt_at(input int c);
    return (c >= MAXC) ? 1'b1 : gnt_pat[c];
  endfunction

  task automatic poke(input int a, input logic [31:0] v);
    pre_we = 1'b1; pre_addr = 12'(a); pre_data = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[a] = v;
  endtask

  // One transfer: gmode 0 = grant always, 1 = toggle 1,0,..., 2 = random.
  task automatic run_op(input string tag, input logic m, input int s, input int d, input int l,
                        input logic [31:0] fv, input int gmode, input logic junk);
    int c;
    for (int i = 0; i < MAXC; i++)
      gnt_pat[i] = (gmode == 0) ? 1'b1 : (gmode == 1) ? (i % 2 == 1) : ($urandom_range(0, 3) != 0);

    // Reference: legality, memory effect, and write/done cycles from the grant pattern.
    exp_err  = (d + l > DEPTH) || (m == 1'b0 && ((s + l > DEPTH) || (d > s && d < s + l)));
    exp_mask = '0;
    if (exp_err || l == 0) begin
      exp_done = 1;
    end else begin
      c = 1;
      for (int k = 0; k < l; k++) begin
        if (m == 1'b0) begin
          while (!gnt_at(c)) c++;
          c++;
        end
        while (!gnt_at(c)) c++;
        if (c < MAXC) exp_mask[c] = 1'b1;
        c++;
      end
      exp_done = c;
      for (int k = 0; k < l; k++) ref_mem[d + k] = (m == 1'b0) ? ref_mem[s + k] : fv;
    end

    start = 1'b1; mode = m; src_addr = 12'(s); dst_addr = 12'(d); len = 13'(l); fill_value = fv;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = 0; we_mask = '0; bad_we = 0; busy_bad = 0; req_seen = 1'b0; err_seen = 1'b0;
    for (int cy = 1; cy < MAXC && done_cyc == 0; cy++) begin
      mem_gnt = gnt_pat[cy];
      if (junk) begin
        start = 1'b1; mode = 1'($urandom); src_addr = 12'($urandom);
        dst_addr = 12'($urandom); len = 13'($urandom); fill_value = $urandom;
      end
      @(negedge clk);
      if (mem_we) begin
        we_mask[cy] = 1'b1;
        if (!mem_gnt) bad_we++;
      end
      if (mem_req) req_seen = 1'b1;
      if (!busy) busy_bad++;
      if (done) begin
        done_cyc = cy;
        err_seen = err;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; mem_gnt = 1'b0;
    check({tag, " done_cycle"}, 128'(done_cyc), 128'(exp_done));
    check({tag, " err"}, 128'(err_seen), 128'(exp_err));
    check({tag, " we_cycles"}, we_mask, exp_mask);
    check({tag, " we_without_gnt"}, 128'(bad_we), 128'(0));
    check({tag, " busy_low"}, 128'(busy_bad), 128'(0));
    check({tag, " req_seen"}, 128'(req_seen), 128'(!(exp_err || l == 0)));
    check({tag, " mem_words_wrong"}, 128'(mem_diffs()), 128'(0));
    @(negedge clk);
    check({tag, " idle_after"}, {126'(0), done, busy}, 128'(0));
  endtask

  initial begin
    int s, d, l, we_after, done_after;
    logic m;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    fill_value = '0; mem_gnt = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    // Preload whole memory under reset.
    for (int i = 0; i < DEPTH; i++) begin
      pre_we = 1'b1; pre_addr = 12'(i); pre_data = $urandom; ref_mem[i] = pre_data;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;

    @(negedge clk);
    check("reset busy", 128'(busy), 128'(0));
    check("reset done", 128'(done), 128'(0));
    check("reset err", 128'(err), 128'(0));
    check("reset mem_we", 128'(mem_we), 128'(0));
    check("reset mem_req", 128'(mem_req), 128'(0));
    check("reset mem_addr", 128'(mem_addr), 128'(0));
    check("reset mem_wd", 128'(mem_wd), 128'(0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: basic copy.
    for (int k = 0; k < 4; k++) poke(16 + k, 32'hA0 + 32'(k));
    run_op("copy4", 1'b0, 12'h010, 12'h100, 4, 32'h0, 0, 1'b0);
    check("copy4 literal done", 128'(done_cyc), 128'(9));
    check("copy4 literal we", we_mask, 128'h154);
    check("copy4 word0", 128'(mem[12'h100]), 128'hA0);
    check("copy4 word3", 128'(mem[12'h103]), 128'hA3);

    // Directed: fill at the top of memory.
    run_op("fill_top", 1'b1, 0, 12'hFFC, 4, 32'hDEADBEEF, 0, 1'b0);
    check("fill_top literal done", 128'(done_cyc), 128'(5));
    check("fill_top literal we", we_mask, 128'h1E);
    check("fill_top last word", 128'(mem[12'hFFF]), 128'hDEADBEEF);

    // Directed: range errors and empty transfer.
    run_op("fill_oob", 1'b1, 0, 12'hFFD, 4, 32'h1234, 0, 1'b0);
    check("fill_oob literal err", 128'(err_seen), 128'(1));
    run_op("copy_overlap", 1'b0, 12'h020, 12'h021, 8, 32'h0, 0, 1'b0);
    check("copy_overlap literal err", 128'(err_seen), 128'(1));
    run_op("len0", 1'b0, 12'h030, 12'h040, 0, 32'h0, 0, 1'b0);
    check("len0 literal done", 128'(done_cyc), 128'(1));

    // Directed: toggling grant, backward-overlapping copy.
    run_op("copy_toggle", 1'b0, 12'h300, 12'h2FF, 3, 32'h0, 1, 1'b0);
    check("copy_toggle literal done", 128'(done_cyc), 128'(12));
    check("copy_toggle literal we", we_mask, 128'h888);

    // Directed: reset in the middle of a 16-word fill.
    start = 1'b1; mode = 1'b1; src_addr = '0; dst_addr = 12'h200; len = 13'd16;
    fill_value = 32'hC0FFEE00; mem_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort mem_we async", 128'(mem_we), 128'(0));
    check("abort busy", 128'(busy), 128'(0));
    for (int k = 0; k < 5; k++) ref_mem[12'h200 + k] = 32'hC0FFEE00;
    @(posedge clk); #3 rst_n = 1'b1;
    we_after = 0; done_after = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_we) we_after++;
      if (done || busy) done_after++;
    end
    mem_gnt = 1'b0;
    check("abort writes after", 128'(we_after), 128'(0));
    check("abort done/busy after", 128'(done_after), 128'(0));
    check("abort mem_words_wrong", 128'(mem_diffs()), 128'(0));
    run_op("after_abort", 1'b0, 12'h200, 12'h400, 6, 32'h0, 0, 1'b0);

    // Directed: in-place copy, with ignored starts while busy.
    run_op("copy_same", 1'b0, 12'h500, 12'h500, 5, 32'h0, 2, 1'b1);

    // Randomized transfers.
    for (int i = 0; i < 30; i++) begin
      m = 1'($urandom_range(0, 1));
      l = int'($urandom_range(0, 12));
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4080, 4095)) : int'($urandom_range(0, 400));
      case ($urandom_range(0, 2))
        0:       d = s + int'($urandom_range(0, 8)) - 4;
        1:       d = int'($urandom_range(0, 4095));
        default: d = int'($urandom_range(4085, 4095));
      endcase
      if (d < 0) d = 0;
      if (d > 4095) d = 4095;
      run_op("rand", m, s, d, l, $urandom, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
# mem_dma

Word-granular DMA engine that acts as the initiator side of the data memory port: it drives word address, write data and write enable, and consumes the asynchronous read data. It either copies a block of words from a source range to a destination range, or fills a destination range with a constant. It sits beside the CPU's load/store path behind an external arbiter, which grants it the single data-memory port cycle by cycle.

## Interface
- MEM_DEPTH, 4096: words in data memory; ADDR_WIDTH = $clog2(MEM_DEPTH) (12).
- DATA_WIDTH, 32: word width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill; sampled with start.
- src_addr  in  ADDR_WIDTH  first source word (copy only).
- dst_addr  in  ADDR_WIDTH  first destination word.
- len  in  ADDR_WIDTH+1  word count, 0..MEM_DEPTH.
- fill_value  in  DATA_WIDTH  fill word; sampled with start.
- mem_gnt  in  1  arbiter grant for the current cycle.
- mem_rd  in  DATA_WIDTH  asynchronous read data from memory.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wd  out  DATA_WIDTH  write data.
- mem_we  out  1  write enable; memory writes on the next rising edge.
- mem_req  out  1  port wanted this cycle (READ or WRITE state).
- busy  out  1  high from the cycle after start acceptance through DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; parameter error, no memory access performed.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE + start: latch src/dst pointers, remaining count, mode and fill_value.
  - Parameter error if dst_addr+len > MEM_DEPTH; or copy mode with src_addr+len > MEM_DEPTH; or copy mode with dst_addr > src_addr and dst_addr < src_addr+len (forward-overlap hazard) -> DONE with err.
  - If there is no error and len==0 -> DONE with err=0.
  - Otherwise go to READ (copy) or WRITE (fill).
- Compute these checks at ADDR_WIDTH+1 bits; there is no wrap-around.
- READ: mem_addr=src_ptr, mem_we=0. If mem_gnt, register mem_rd into data_q and go to WRITE; otherwise hold.
- WRITE: mem_addr=dst_ptr, mem_wd = data_q (copy) or fill_value (fill), mem_we = mem_gnt. If mem_gnt, increment the pointers and decrement the count.
  - Count reaches 0 -> DONE.
  - Else copy goes to READ; fill stays in WRITE.
- DONE: done=1 for one cycle, err as determined, then IDLE.
- start outside IDLE is ignored.
- mem_we must never be high outside WRITE with mem_gnt.
- Overlap with dst_addr < src_addr, or dst_addr == src_addr, is legal and gives a correct forward copy.

## Timing
- Reset values: state IDLE, busy=0, done=0, err=0, mem_we=0, mem_req=0, mem_addr=0, mem_wd=0.
- rst_n assertion mid-transfer aborts immediately:
  - mem_we drops asynchronously.
  - Words already written stay written.
  - No done is produced.
- Take start at edge 0 and hold mem_gnt=1.
  - Copy: word k (1..N) is read in cycle 2k-1 and written in cycle 2k; done is high in cycle 2N+1.
  - Fill: word k is written in cycle k; done is high in cycle N+1.
  - Error or len=0: done is high in cycle 1.
- Each cycle with mem_gnt=0 in READ or WRITE adds exactly one cycle.
- A new start is accepted in the cycle after done, i.e. back in IDLE.

## Structure
- Package mem_dma_pkg holds:
  - the state enum (IDLE, READ, WRITE, DONE);
  - the mode constants MODE_COPY=0 and MODE_FILL=1.
- One sub-module is natural: mem_dma_range_check, combinational. It produces the error flag from src, dst, len, mode and MEM_DEPTH.
- Bench memory is a behavioural model of the data memory with asynchronous read and synchronous write.

## Test plan
- Copy, src=0x010, dst=0x100, len=4, memory preloaded with 0xA0..0xA3, mem_gnt=1:
  - mem[0x100..0x103]=0xA0..0xA3;
  - done in cycle 9, err=0;
  - mem_we high in cycles 2, 4, 6, 8 only.
- Fill, dst=0xFFC, len=4, fill_value=0xDEADBEEF: mem[0xFFC..0xFFF] written in cycles 1-4, done in cycle 5.
- Range errors, each giving done+err in cycle 1 with zero mem_we:
  - fill, dst=0xFFD, len=4;
  - copy, src=0x020, dst=0x021, len=8 (overlap).
- len=0 -> done in cycle 1, err=0, mem_req never high.
- Copy with len=3 and mem_gnt toggling 1,0,1,0,...: data still correct, each stall adds one cycle, and mem_we is never high while mem_gnt=0.
- rst_n pulsed low in the middle of a 16-word fill:
  - mem_we low during reset and no further writes afterwards;
  - busy=0, no done;
  - the next start runs normally.
